// File: rtl/pwqe_slot_mgr_pkg.sv
// Shared types for the PWQE station-buffer slot manager.
package pwqe_slot_mgr_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        ALLOC    = 2'd1,
        ACTIVE   = 2'd2,
        INFLIGHT = 2'd3
    } slot_state_e;

endpackage

// File: rtl/pwqe_slot_mgr_if.sv
// Event/status bundle between ingress, scheduler, transport and the slot manager.
interface pwqe_slot_mgr_if #(
    parameter int N  = 4,
    parameter int AW = 2
);
    logic          i_alloc_req;
    logic          o_alloc_rdy;
    logic [AW-1:0] o_alloc_addr;
    logic          i_load_done;
    logic [AW-1:0] i_load_addr;
    logic          i_disp_val;
    logic [AW-1:0] i_disp_addr;
    logic          i_pwqe_wb;
    logic [AW-1:0] i_pwqe_addr;
    logic          i_pwqe_last;
    logic [N-1:0]  o_slot_status;
    logic [AW:0]   o_free_cnt;
    logic          o_err;

    modport master (
        output i_alloc_req, i_load_done, i_load_addr, i_disp_val, i_disp_addr,
               i_pwqe_wb, i_pwqe_addr, i_pwqe_last,
        input  o_alloc_rdy, o_alloc_addr, o_slot_status, o_free_cnt, o_err
    );

    modport slave (
        input  i_alloc_req, i_load_done, i_load_addr, i_disp_val, i_disp_addr,
               i_pwqe_wb, i_pwqe_addr, i_pwqe_last,
        output o_alloc_rdy, o_alloc_addr, o_slot_status, o_free_cnt, o_err
    );
endinterface

// File: rtl/pwqe_slot_mgr_lsb_free_enc.sv
// Lowest-set-bit encoder: picks the lowest-index FREE slot.
module pwqe_slot_mgr_lsb_free_enc #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  i_free_mask,
    output logic [AW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_idx = '0;
        // Scan high to low so the last hit written is the lowest index.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_free_mask[k]) o_idx = AW'(k);
        end
        o_any = |i_free_mask;
    end

endmodule

// File: rtl/pwqe_slot_mgr.sv
// Per-slot lifecycle tracker for the PWQE station buffer: allocation, load,
// dispatch and write-back, plus the schedulable-slot mask and free counter.
module pwqe_slot_mgr
    import pwqe_slot_mgr_pkg::*;
#(
    parameter int PWQE_SLOT_NUM       = 4,
    parameter int PWQE_BUF_ADDR_WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pwqe_slot_mgr_if.slave bus
);

    localparam int N  = PWQE_SLOT_NUM;
    localparam int AW = PWQE_BUF_ADDR_WIDTH;

    slot_state_e   state_q [N];
    slot_state_e   state_d [N];
    logic [AW:0]   free_cnt_q, free_cnt_d;
    logic          err_q, err_d;

    logic [N-1:0]  free_mask;
    logic [N-1:0]  active_mask;
    logic [AW-1:0] alloc_addr;
    logic          alloc_rdy;
    logic          alloc_fire;
    logic          release_slot;

    always_comb begin
        free_mask   = '0;
        active_mask = '0;
        for (int k = 0; k < N; k++) begin
            free_mask[k]   = (state_q[k] == FREE);
            active_mask[k] = (state_q[k] == ACTIVE);
        end
    end

    pwqe_slot_mgr_lsb_free_enc #(
        .N  (N),
        .AW (AW)
    ) u_free_enc (
        .i_free_mask (free_mask),
        .o_idx       (alloc_addr),
        .o_any       (alloc_rdy)
    );

    assign alloc_fire = bus.i_alloc_req && alloc_rdy;

    always_comb begin
        logic hit_a, hit_l, hit_d, hit_w, bad;
        err_d        = err_q;
        release_slot = 1'b0;
        for (int k = 0; k < N; k++) begin
            hit_a = alloc_fire      && (alloc_addr      == AW'(k));
            hit_l = bus.i_load_done && (bus.i_load_addr == AW'(k));
            hit_d = bus.i_disp_val  && (bus.i_disp_addr == AW'(k));
            hit_w = bus.i_pwqe_wb   && (bus.i_pwqe_addr == AW'(k));
            // Wrong-state events and same-slot collisions freeze the slot.
            bad = (hit_l && state_q[k] != ALLOC)
               || (hit_d && state_q[k] != ACTIVE)
               || (hit_w && state_q[k] != INFLIGHT)
               || (hit_d && hit_w)
               || (hit_l && hit_d);
            state_d[k] = state_q[k];
            if (bad) err_d = 1'b1;
            // A granted alloc is always honoured; it only ever targets a FREE slot.
            if (hit_a) begin
                state_d[k] = ALLOC;
            end else if (!bad) begin
                if (hit_l) begin
                    state_d[k] = ACTIVE;
                end else if (hit_d) begin
                    state_d[k] = INFLIGHT;
                end else if (hit_w) begin
                    state_d[k] = bus.i_pwqe_last ? FREE : ACTIVE;
                    if (bus.i_pwqe_last) release_slot = 1'b1;
                end
            end
        end
        free_cnt_d = free_cnt_q + {{AW{1'b0}}, release_slot} - {{AW{1'b0}}, alloc_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) state_q[k] <= FREE;
            free_cnt_q <= (AW + 1)'(N);
            err_q      <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) state_q[k] <= state_d[k];
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_alloc_rdy   = alloc_rdy;
    assign bus.o_alloc_addr  = alloc_addr;
    assign bus.o_slot_status = active_mask;
    assign bus.o_free_cnt    = free_cnt_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_pwqe_slot_mgr.sv
// Directed bench for pwqe_slot_mgr with N=4 slots.
module tb_pwqe_slot_mgr;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pwqe_slot_mgr_if #(.N(4), .AW(2)) bus ();

    pwqe_slot_mgr #(
        .PWQE_SLOT_NUM       (4),
        .PWQE_BUF_ADDR_WIDTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.i_alloc_req = 1'b0;
        bus.i_load_done = 1'b0;
        bus.i_load_addr = 2'd0;
        bus.i_disp_val  = 1'b0;
        bus.i_disp_addr = 2'd0;
        bus.i_pwqe_wb   = 1'b0;
        bus.i_pwqe_addr = 2'd0;
        bus.i_pwqe_last = 1'b0;
    endtask

    // One clock with the given events applied; inputs cleared afterwards.
    task automatic cyc(input logic a, input logic l, input logic [1:0] la,
                       input logic d, input logic [1:0] da,
                       input logic w, input logic [1:0] wa, input logic wl);
        bus.i_alloc_req = a;
        bus.i_load_done = l;
        bus.i_load_addr = la;
        bus.i_disp_val  = d;
        bus.i_disp_addr = da;
        bus.i_pwqe_wb   = w;
        bus.i_pwqe_addr = wa;
        bus.i_pwqe_last = wl;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL reset_status got=%b exp=0000", bus.o_slot_status); end
        checks++; if (bus.o_free_cnt !== 3'd4) begin errors++; $display("FAIL reset_free_cnt got=%0d exp=4", bus.o_free_cnt); end
        checks++; if (bus.o_alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", bus.o_alloc_rdy); end
        checks++; if (bus.o_alloc_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.o_alloc_addr); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
    endtask

    task automatic test_alloc_fill();
        apply_reset();
        bus.i_alloc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic       exp_rdy;
            logic [2:0] exp_cnt;
            logic [1:0] exp_addr;
            exp_rdy  = (i < 4);
            exp_addr = 2'(i);
            exp_cnt  = (i < 4) ? 3'(3 - i) : 3'd0;
            checks++; if (bus.o_alloc_rdy !== exp_rdy) begin errors++; $display("FAIL fill_rdy[%0d] got=%b exp=%b", i, bus.o_alloc_rdy, exp_rdy); end
            if (i < 4) begin
                checks++; if (bus.o_alloc_addr !== exp_addr) begin errors++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, bus.o_alloc_addr, exp_addr); end
            end
            @(posedge clk);
            #1;
            checks++; if (bus.o_free_cnt !== exp_cnt) begin errors++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, bus.o_free_cnt, exp_cnt); end
        end
        bus.i_alloc_req = 1'b0;
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL fill_err got=%b exp=0", bus.o_err); end
    endtask

    task automatic test_lifecycle();
        logic [3:0] exp_st [4];
        exp_st = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        apply_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_free_cnt !== 3'd3) begin errors++; $display("FAIL life_cnt_alloc got=%0d exp=3", bus.o_free_cnt); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== exp_st[0]) begin errors++; $display("FAIL life_load got=%b exp=%b", bus.o_slot_status, exp_st[0]); end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== exp_st[1]) begin errors++; $display("FAIL life_disp got=%b exp=%b", bus.o_slot_status, exp_st[1]); end
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.o_slot_status !== exp_st[2]) begin errors++; $display("FAIL life_wb got=%b exp=%b", bus.o_slot_status, exp_st[2]); end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== exp_st[3]) begin errors++; $display("FAIL life_disp2 got=%b exp=%b", bus.o_slot_status, exp_st[3]); end
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        checks++; if (bus.o_free_cnt !== 3'd4) begin errors++; $display("FAIL life_cnt_rel got=%0d exp=4", bus.o_free_cnt); end
        checks++; if (bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL life_status_rel got=%b exp=0000", bus.o_slot_status); end
        checks++; if (bus.o_alloc_rdy !== 1'b1 || bus.o_alloc_addr !== 2'd0) begin errors++; $display("FAIL life_slot0_free got=rdy%b/addr%0d exp=rdy1/addr0", bus.o_alloc_rdy, bus.o_alloc_addr); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL life_err got=%b exp=0", bus.o_err); end
    endtask

    task automatic test_release_alloc_same_cycle();
        apply_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 2'(k), 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 2'(k), 0, 0, 0);
        checks++; if (bus.o_free_cnt !== 3'd0 || bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL rel_setup got=cnt%0d/st%b exp=cnt0/st0000", bus.o_free_cnt, bus.o_slot_status); end
        bus.i_alloc_req = 1'b1;
        bus.i_pwqe_wb   = 1'b1;
        bus.i_pwqe_addr = 2'd2;
        bus.i_pwqe_last = 1'b1;
        #1;
        checks++; if (bus.o_alloc_rdy !== 1'b0) begin errors++; $display("FAIL rel_no_grant got=%b exp=0", bus.o_alloc_rdy); end
        @(posedge clk);
        #1;
        bus.i_pwqe_wb   = 1'b0;
        bus.i_pwqe_last = 1'b0;
        checks++; if (bus.o_alloc_rdy !== 1'b1 || bus.o_alloc_addr !== 2'd2) begin errors++; $display("FAIL rel_next_grant got=rdy%b/addr%0d exp=rdy1/addr2", bus.o_alloc_rdy, bus.o_alloc_addr); end
        checks++; if (bus.o_free_cnt !== 3'd1) begin errors++; $display("FAIL rel_cnt1 got=%0d exp=1", bus.o_free_cnt); end
        @(posedge clk);
        #1;
        bus.i_alloc_req = 1'b0;
        checks++; if (bus.o_free_cnt !== 3'd0 || bus.o_alloc_rdy !== 1'b0) begin errors++; $display("FAIL rel_cnt0 got=cnt%0d/rdy%b exp=cnt0/rdy0", bus.o_free_cnt, bus.o_alloc_rdy); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rel_err got=%b exp=0", bus.o_err); end
    endtask

    task automatic test_concurrent_events();
        apply_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 1);
        checks++; if (bus.o_slot_status !== 4'b0001 || bus.o_alloc_addr !== 2'd2 || bus.o_free_cnt !== 3'd1) begin errors++; $display("FAIL conc_setup got=st%b/addr%0d/cnt%0d exp=st0001/addr2/cnt1", bus.o_slot_status, bus.o_alloc_addr, bus.o_free_cnt); end
        cyc(1, 1, 1, 1, 0, 1, 3, 0);
        checks++; if (bus.o_slot_status !== 4'b1010) begin errors++; $display("FAIL conc_status got=%b exp=1010", bus.o_slot_status); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL conc_err got=%b exp=0", bus.o_err); end
        checks++; if (bus.o_free_cnt !== 3'd0 || bus.o_alloc_rdy !== 1'b0) begin errors++; $display("FAIL conc_cnt got=cnt%0d/rdy%b exp=cnt0/rdy0", bus.o_free_cnt, bus.o_alloc_rdy); end
        // Slot 0 must be INFLIGHT: a non-last write-back returns it to ACTIVE.
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.o_slot_status !== 4'b1011 || bus.o_err !== 1'b0) begin errors++; $display("FAIL conc_slot0 got=st%b/err%b exp=st1011/err0", bus.o_slot_status, bus.o_err); end
        // Slot 2 must be ALLOC: a load makes it ACTIVE.
        cyc(0, 1, 2, 0, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== 4'b1111 || bus.o_err !== 1'b0) begin errors++; $display("FAIL conc_slot2 got=st%b/err%b exp=st1111/err0", bus.o_slot_status, bus.o_err); end
    endtask

    task automatic test_illegal_disp();
        apply_reset();
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL ill_err_set got=%b exp=1", bus.o_err); end
        checks++; if (bus.o_slot_status !== 4'b0000 || bus.o_free_cnt !== 3'd4) begin errors++; $display("FAIL ill_unchanged got=st%b/cnt%0d exp=st0000/cnt4", bus.o_slot_status, bus.o_free_cnt); end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky got=%b exp=1", bus.o_err); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_alloc_addr !== 2'd1 || bus.o_free_cnt !== 3'd3) begin errors++; $display("FAIL ill_slot1_free got=addr%0d/cnt%0d exp=addr1/cnt3", bus.o_alloc_addr, bus.o_free_cnt); end
    endtask

    task automatic test_collisions();
        apply_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        checks++; if (bus.o_err !== 1'b1 || bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL col_load_disp got=err%b/st%b exp=err1/st0000", bus.o_err, bus.o_slot_status); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== 4'b0001) begin errors++; $display("FAIL col_still_alloc got=%b exp=0001", bus.o_slot_status); end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 1);
        checks++; if (bus.o_free_cnt !== 3'd3 || bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL col_disp_wb got=cnt%0d/st%b exp=cnt3/st0000", bus.o_free_cnt, bus.o_slot_status); end
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        checks++; if (bus.o_free_cnt !== 3'd4) begin errors++; $display("FAIL col_still_inflight got=%0d exp=4", bus.o_free_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 2'(k), 0, 0, 0, 0, 0);
        checks++; if (bus.o_slot_status !== 4'b0111 || bus.o_free_cnt !== 3'd1) begin errors++; $display("FAIL ares_setup got=st%b/cnt%0d exp=st0111/cnt1", bus.o_slot_status, bus.o_free_cnt); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_slot_status !== 4'b0000) begin errors++; $display("FAIL ares_status got=%b exp=0000", bus.o_slot_status); end
        checks++; if (bus.o_free_cnt !== 3'd4) begin errors++; $display("FAIL ares_cnt got=%0d exp=4", bus.o_free_cnt); end
        checks++; if (bus.o_alloc_rdy !== 1'b1 || bus.o_alloc_addr !== 2'd0) begin errors++; $display("FAIL ares_alloc got=rdy%b/addr%0d exp=rdy1/addr0", bus.o_alloc_rdy, bus.o_alloc_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_alloc_fill();
        test_lifecycle();
        test_release_alloc_same_cycle();
        test_concurrent_events();
        test_illegal_disp();
        test_collisions();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
